// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the instruction fetch queue.
package fetch_queue_pkg;
  localparam int InstW = 32;
  localparam logic [InstW-1:0] ZeroWord = '0;
  localparam int PcMaxW = 64;
  // Bit n set means MEM_W = n bytes per beat is supported.
  localparam logic [4:0] LegalMemW = 5'b10110;

  typedef struct packed {
    logic [InstW-1:0]  inst;
    logic [PcMaxW-1:0] pc;
  } fq_entry_t;

  function automatic logic mem_w_ok(input int w);
    return (w >= 0 && w <= 4) ? LegalMemW[w[2:0]] : 1'b0;
  endfunction
endpackage

// File: rtl/fq_storage.sv
// Circular register array holding queued {inst, pc} entries; head is read combinationally.
module fq_storage #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         we_i,
  input  logic         re_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [PW-1:0]           wptr_q, rptr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (we_i) wptr_q <= wptr_q + 1'b1;
      if (re_i) rptr_q <= rptr_q + 1'b1;
    end
  end

  // Data needs no reset: the top masks the head while the queue is empty.
  always_ff @(posedge clk_i) begin
    if (we_i && !clr_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: assembles 32-bit words from MEM_W-byte beats or cache hits.
// Define FETCH_QUEUE_BYPASS_EN to forward a completing push to id_* when the queue is empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int MEM_W  = 1,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic [ADDR_W-1:0]    flush_pc,
  output logic                 mem_req,
  input  logic                 mem_valid,
  input  logic [8*MEM_W-1:0]   mem_data,
  input  logic                 hit,
  input  logic [InstW-1:0]     hit_inst,
  output logic                 id_valid,
  input  logic                 id_ready,
  output logic [InstW-1:0]     id_inst,
  output logic [ADDR_W-1:0]    id_pc,
  output logic                 ovf
);
  localparam int Beats  = 4 / MEM_W;
  localparam int CntW   = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int CountW = $clog2(DEPTH) + 1;
  localparam int EntW   = InstW + ADDR_W;
  localparam logic [CntW-1:0]   LastBeat = CntW'(Beats - 1);
  localparam logic [CountW-1:0] FullCnt  = CountW'(DEPTH);

  if (!mem_w_ok(MEM_W)) begin : g_bad_mem_w
    $error("fetch_queue: MEM_W must be 1, 2 or 4");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of two >= 2");
  end

  logic [CountW-1:0] count_q, count_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [InstW-1:0]  asm_q, asm_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic              ovf_q, ovf_d;

  logic              live, full, empty, pop_q, blocked, beat_acc, hit_acc;
  logic              push, byp, byp_take, we;
  logic [InstW-1:0]  asm_w, push_inst;
  logic [EntW-1:0]   head;

  always_comb begin
    live     = rdy && !flush;
    full     = (count_q == FullCnt);
    empty    = (count_q == '0);
    pop_q    = live && !empty && id_ready;
    blocked  = full && !pop_q;
    beat_acc = live && mem_valid;
    hit_acc  = live && hit && !mem_valid && (cnt_q == '0);

    asm_w = asm_q;
    asm_w[int'(cnt_q)*(8*MEM_W) +: 8*MEM_W] = mem_data;
    push_inst = hit_acc ? hit_inst : asm_w;
    push = ((beat_acc && cnt_q == LastBeat) || hit_acc) && !blocked;

`ifdef FETCH_QUEUE_BYPASS_EN
    byp = push && empty;
`else
    byp = 1'b0;
`endif
    byp_take = byp && id_ready;
    we       = push && !byp_take;

    count_d = count_q;
    if (we && !pop_q)      count_d = count_q + 1'b1;
    else if (pop_q && !we) count_d = count_q - 1'b1;

    cnt_d = cnt_q;
    asm_d = asm_q;
    if (beat_acc && !blocked) begin
      cnt_d = (cnt_q == LastBeat) ? '0 : cnt_q + 1'b1;
      asm_d = asm_w;
    end
    fpc_d = push ? fpc_q + ADDR_W'(4) : fpc_q;
    ovf_d = ovf_q | ((beat_acc || hit_acc) && blocked);

    // Redirect outranks everything, including a frozen pipeline.
    if (flush) begin
      count_d = '0;
      cnt_d   = '0;
      asm_d   = ZeroWord;
      fpc_d   = flush_pc;
    end else if (!rdy) begin
      count_d = count_q;
      cnt_d   = cnt_q;
      asm_d   = asm_q;
      fpc_d   = fpc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      cnt_q   <= '0;
      asm_q   <= ZeroWord;
      fpc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      fpc_q   <= fpc_d;
      ovf_q   <= ovf_d;
    end
  end

  fq_storage #(.DEPTH(DEPTH), .W(EntW)) u_storage (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (flush),
    .we_i   (we),
    .re_i   (pop_q),
    .wdata_i({push_inst, fpc_q}),
    .rdata_o(head)
  );

  always_comb begin
    mem_req  = !rst && live && (!full || pop_q);
    id_valid = !empty || byp;
    id_inst  = ZeroWord;
    id_pc    = '0;
    if (!empty) begin
      id_inst = head[EntW-1 -: InstW];
      id_pc   = head[ADDR_W-1:0];
    end else if (byp) begin
      id_inst = push_inst;
      id_pc   = fpc_q;
    end
  end

  assign ovf = ovf_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: byte-beat instance with a queue-level model checked every cycle,
// plus a word-beat instance driven with directed vectors.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance A: MEM_W=1
  logic        rdy, flush, mem_valid, hit, id_ready;
  logic [31:0] flush_pc, hit_inst;
  logic [7:0]  mem_data;
  logic        mem_req, id_valid, ovf;
  logic [31:0] id_inst, id_pc;

  // Instance B: MEM_W=4
  logic        b_rdy, b_flush, b_hit, b_mem_valid, b_id_ready;
  logic [31:0] b_flush_pc, b_hit_inst, b_mem_data;
  logic        b_mem_req, b_id_valid, b_ovf;
  logic [31:0] b_id_inst, b_id_pc;

  fetch_queue #(.MEM_W(1), .DEPTH(4), .ADDR_W(32)) u_dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .flush_pc(flush_pc),
    .mem_req(mem_req), .mem_valid(mem_valid), .mem_data(mem_data),
    .hit(hit), .hit_inst(hit_inst), .id_valid(id_valid), .id_ready(id_ready),
    .id_inst(id_inst), .id_pc(id_pc), .ovf(ovf));

  fetch_queue #(.MEM_W(4), .DEPTH(4), .ADDR_W(32)) u_dut_w (
    .clk(clk), .rst(rst), .rdy(b_rdy), .flush(b_flush), .flush_pc(b_flush_pc),
    .mem_req(b_mem_req), .mem_valid(b_mem_valid), .mem_data(b_mem_data),
    .hit(b_hit), .hit_inst(b_hit_inst), .id_valid(b_id_valid), .id_ready(b_id_ready),
    .id_inst(b_id_inst), .id_pc(b_id_pc), .ovf(b_ovf));

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model of instance A: a queue of whole entries plus the bytes gathered so far.
  fq_entry_t   mq[$];
  logic [7:0]  mb[$];
  logic [31:0] mfpc = '0;
  logic        movf = 1'b0;

  function automatic void cur_push(output bit p, output fq_entry_t e);
    bit live, popq, blocked;
    live    = rdy && !flush && !rst;
    popq    = live && mq.size() > 0 && id_ready;
    blocked = mq.size() == 4 && !popq;
    p = 1'b0;
    e = '0;
    if (live && !blocked) begin
      if (mem_valid && mb.size() == 3) begin
        p = 1'b1; e.inst = {mem_data, mb[2], mb[1], mb[0]}; e.pc = 64'(mfpc);
      end else if (!mem_valid && hit && mb.size() == 0) begin
        p = 1'b1; e.inst = hit_inst; e.pc = 64'(mfpc);
      end
    end
  endfunction

  initial begin
    forever begin
      bit p, was_empty, popq, blocked, ev, emr;
      fq_entry_t e;
      logic [31:0] ei, ep;
      @(negedge clk);
      if (rst) begin
        mq.delete(); mb.delete(); mfpc = '0; movf = 1'b0;
      end
      cur_push(p, e);
      ev = mq.size() > 0;
      ei = ev ? mq[0].inst : 32'h0;
      ep = ev ? mq[0].pc[31:0] : 32'h0;
      if (Byp && !ev && p) begin
        ev = 1'b1; ei = e.inst; ep = e.pc[31:0];
      end
      emr = !rst && rdy && !flush && (mq.size() < 4 || (mq.size() > 0 && id_ready));
      chk("A.id_valid", id_valid, ev);
      chk("A.id_inst", id_inst, ei);
      chk("A.id_pc", id_pc, ep);
      chk("A.mem_req", mem_req, emr);
      chk("A.ovf", ovf, movf);
      // advance the model by the upcoming rising edge
      if (rst) begin
      end else if (flush) begin
        mq.delete(); mb.delete(); mfpc = flush_pc;
      end else if (rdy) begin
        was_empty = mq.size() == 0;
        popq      = !was_empty && id_ready;
        blocked   = mq.size() == 4 && !popq;
        if (blocked && (mem_valid || (hit && mb.size() == 0))) movf = 1'b1;
        if (!blocked && mem_valid) begin
          if (p) mb.delete();
          else mb.push_back(mem_data);
        end
        if (popq) void'(mq.pop_front());
        if (p) begin
          mfpc += 32'd4;
          if (!(Byp && was_empty && id_ready)) mq.push_back(e);
        end
      end
    end
  end

  task automatic step(input logic mv, input logic [7:0] d, input logic h,
                      input logic [31:0] hi, input logic rd);
    mem_valid = mv; mem_data = d; hit = h; hit_inst = hi; id_ready = rd;
    @(posedge clk); #1;
  endtask

  task automatic bstep(input logic mv, input logic [31:0] d, input logic rd);
    b_mem_valid = mv; b_mem_data = d; b_id_ready = rd;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; flush_pc = '0;
    mem_valid = 1'b0; mem_data = '0; hit = 1'b0; hit_inst = '0; id_ready = 1'b0;
    b_rdy = 1'b1; b_flush = 1'b0; b_flush_pc = '0; b_hit = 1'b0; b_hit_inst = '0;
    b_mem_valid = 1'b0; b_mem_data = '0; b_id_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst id_valid", id_valid, 1'b0);
    chk("rst id_inst", id_inst, 32'h0);
    chk("rst id_pc", id_pc, 32'h0);
    chk("rst mem_req", mem_req, 1'b0);
    chk("rst B id_valid", b_id_valid, 1'b0);
    rst = 1'b0;

    // four byte beats assemble one instruction
    step(1, 8'h13, 0, 0, 0); step(1, 8'h05, 0, 0, 0); step(1, 8'h10, 0, 0, 0);
    chk("beat3 id_valid", id_valid, 1'b0);
    step(1, 8'h00, 0, 0, 0);
    chk("beat4 id_valid", id_valid, 1'b1);
    chk("beat4 id_inst", id_inst, 32'h00100513);
    chk("beat4 id_pc", id_pc, 32'h0);

    // hit at counter 0 pushes; hit mid-assembly is ignored
    step(0, 0, 1, 32'h00000013, 0);
    step(1, 8'hb1, 0, 0, 0); step(1, 8'hc2, 0, 0, 0);
    step(0, 0, 1, 32'hdeadbeef, 0);
    step(1, 8'hd3, 0, 0, 0); step(1, 8'he4, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("hit head pc", id_pc, 32'h4);
    chk("hit head inst", id_inst, 32'h00000013);
    step(0, 0, 0, 0, 1);
    chk("mixed head pc", id_pc, 32'h8);
    chk("mixed head inst", id_inst, 32'he4d3c2b1);
    step(0, 0, 0, 0, 1);
    chk("drained id_valid", id_valid, 1'b0);

    // flush mid-assembly with a queued entry
    step(0, 0, 1, 32'h00000033, 0);
    step(1, 8'h11, 0, 0, 0); step(1, 8'h22, 0, 0, 0);
    flush = 1'b1; flush_pc = 32'h100;
    step(1, 8'h33, 0, 0, 0);
    flush = 1'b0;
    chk("flush id_valid", id_valid, 1'b0);
    step(1, 8'haa, 0, 0, 0); step(1, 8'hbb, 0, 0, 0);
    step(1, 8'hcc, 0, 0, 0); step(1, 8'hdd, 0, 0, 0);
    chk("post-flush pc", id_pc, 32'h100);
    chk("post-flush inst", id_inst, 32'hddccbbaa);

    // frozen pipeline: no pop, no beat
    rdy = 1'b0;
    step(1, 8'h55, 0, 0, 1);
    rdy = 1'b1;
    chk("rdy low held", id_pc, 32'h100);

    // fill, then overflow
    repeat (3) step(0, 0, 1, 32'h00001000, 0);
    step(1, 8'h77, 0, 0, 0);
    chk("A ovf", ovf, 1'b1);
    chk("A ovf head", id_pc, 32'h100);
    repeat (4) step(0, 0, 0, 0, 1);

    // reset mid-assembly
    step(1, 8'h0a, 0, 0, 0); step(1, 8'h0b, 0, 0, 0);
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    rst = 1'b0;
    step(1, 8'h01, 0, 0, 0); step(1, 8'h02, 0, 0, 0);
    step(1, 8'h03, 0, 0, 0); step(1, 8'h04, 0, 0, 0);
    chk("post-rst pc", id_pc, 32'h0);
    chk("post-rst inst", id_inst, 32'h04030201);
    chk("post-rst ovf", ovf, 1'b0);
    step(0, 0, 0, 0, 1);

    // empty queue, hit with decode ready
    mem_valid = 1'b0; hit = 1'b1; hit_inst = 32'h00000013; id_ready = 1'b1;
    #1;
    chk("empty hit same-cycle valid", id_valid, Byp);
    @(posedge clk); #1;
    hit = 1'b0; id_ready = 1'b0;
    #1;
    chk("empty hit next-cycle valid", id_valid, !Byp);
    step(0, 0, 0, 0, 1);

    // word-beat instance: push with pop at full, then overflow
    for (int i = 0; i < 4; i++) bstep(1, 32'ha0000000 + i, 0);
    chk("B full mem_req", b_mem_req, 1'b0);
    chk("B full head pc", b_id_pc, 32'h0);
    bstep(1, 32'ha0000004, 1);
    b_id_ready = 1'b0; #1;
    chk("B push+pop mem_req", b_mem_req, 1'b0);
    chk("B push+pop head", b_id_inst, 32'ha0000001);
    chk("B push+pop ovf", b_ovf, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      chk("B drain inst", b_id_inst, 32'ha0000000 + i);
      chk("B drain pc", b_id_pc, 32'(4 * i));
      bstep(0, 0, 1);
    end
    chk("B drained", b_id_valid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bstep(1, 32'hb0000000 + i, 0);
      if (i == 3) chk("B mem_req after 4", b_mem_req, 1'b0);
    end
    chk("B ovf", b_ovf, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("B ovf inst", b_id_inst, 32'hb0000000 + i);
      chk("B ovf pc", b_id_pc, 32'h14 + 32'(4 * i));
      bstep(0, 0, 1);
    end
    chk("B ovf drained", b_id_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter MEM_W, default 1, bytes per memory beat; legal values 1, 2, 4.
REQ-002 Parameter DEPTH, default 4, instruction queue entries; power of two, >= 2.
REQ-003 Parameter ADDR_W, default 32, program-counter width.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 rdy  input  1  global ready; low freezes all state.
REQ-007 flush  input  1  jump/redirect; discard queue and partial assembly.
REQ-008 flush_pc  input  ADDR_W  new fetch address on flush.
REQ-009 mem_req  output  1  request next beat from memory.
REQ-010 mem_valid  input  1  beat present on mem_data.
REQ-011 mem_data  input  8*MEM_W  beat bytes, lowest address in bits [7:0].
REQ-012 hit  input  1  cache supplies whole instruction this cycle.
REQ-013 hit_inst  input  32  cached instruction at current fetch pc.
REQ-014 id_valid  output  1  head entry valid.
REQ-015 id_ready  input  1  decode accepts head entry.
REQ-016 id_inst  output  32  head instruction.
REQ-017 id_pc  output  ADDR_W  head instruction address.
REQ-018 ovf  output  1  sticky: beat or hit arrived with queue full.

Function
REQ-019 Fetch pc register (fpc) holds address of instruction being assembled; increments by 4 on each push.
REQ-020 Beat counter counts 0 .. 4/MEM_W-1; each accepted beat places bytes at byte offset cnt*MEM_W of assembly register.
REQ-021 Final beat pushes {assembled word with final beat bytes, fpc} into queue in the same edge; counter returns to 0.
REQ-022 hit with counter 0 and no mem_valid pushes {hit_inst, fpc} in one cycle; hit with counter != 0 or simultaneous mem_valid is ignored (beat path wins).
REQ-023 Pop occurs when id_valid && id_ready; order strictly FIFO.
REQ-024 Push and pop in same cycle permitted at any occupancy including full; count unchanged.
REQ-025 mem_req = rdy && !flush && (count < DEPTH || pop this cycle).
REQ-026 Beat or hit arriving when full and no pop: discarded, state unchanged, ovf set until reset.
REQ-027 flush (highest priority): count, read/write pointers, beat counter cleared; fpc <= flush_pc; any beat/hit/pop that cycle discarded; id_valid low next cycle.
REQ-028 rdy low: no state change, mem_req low, id_valid held, no pop.
REQ-029 Pointers wrap modulo DEPTH; count width $clog2(DEPTH)+1.
REQ-030 Latency without bypass: pushed entry visible on id_* one cycle after push edge.

Reset
REQ-031 On rst: count, pointers, beat counter, fpc, ovf = 0; id_valid = 0; id_inst = 0; id_pc = 0; mem_req = 0 while rst high.
REQ-032 Reset mid-assembly discards partial bytes; first post-reset instruction starts at pc 0.

Configuration
REQ-033 Macro FETCH_QUEUE_BYPASS_EN defined: when queue empty, completing push (final beat or hit) drives id_valid/id_inst/id_pc combinationally same cycle; if id_ready, entry not written.
REQ-034 Macro undefined: no combinational path from mem_data/hit_inst to id_*; REQ-030 latency applies.

Structure
REQ-035 Shared package holds ZeroWord, instruction width 32, legal MEM_W check constant, and queue-entry struct {inst, pc}.
REQ-036 One sub-module fq_storage: DEPTH x (32+ADDR_W) register array with write/read pointers; assembly, counters and control in top.

Verification
REQ-037 MEM_W=1: bytes 0x13,0x05,0x10,0x00 on 4 consecutive cycles from reset -> id_inst 0x00100513, id_pc 0x0 one cycle after 4th beat (bypass off).
REQ-038 MEM_W=4, DEPTH=4, id_ready=0: 5 beats -> 4 entries, mem_req low after 4th, 5th beat sets ovf=1, queue contents unchanged.
REQ-039 MEM_W=1, flush with flush_pc=0x100 after 2 beats -> partial discarded; next 4 beats produce id_pc 0x100.
REQ-040 hit=1, hit_inst=0x00000013 at counter 0 -> entry id_pc=fpc in one cycle; hit during counter=2 ignored.
REQ-041 Full queue, id_ready=1, beat completing same cycle -> count stays DEPTH, order preserved, ovf stays 0.
REQ-042 Bypass on, empty queue, id_ready=1, hit=1 -> id_valid=1 and id_inst=hit_inst same cycle, count remains 0.
